// File: rtl/cycle_sequencer_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 phase sequencer.
package cycle_sequencer_pkg;

  localparam int unsigned SEQ_STATE_W = 3;
  localparam int unsigned OPCODE_W    = 11;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 11'h7FF;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_FETCH     = 3'd1,
    SEQ_DECODE    = 3'd2,
    SEQ_EXECUTE   = 3'd3,
    SEQ_MEMORY    = 3'd4,
    SEQ_WRITEBACK = 3'd5,
    SEQ_HALT      = 3'd6
  } seq_state_e;

  // IDLE and HALT are the only parked states; everything else is mid-instruction.
  function automatic logic seq_is_busy(input seq_state_e s);
    return !((s == SEQ_IDLE) || (s == SEQ_HALT));
  endfunction

endpackage

// File: rtl/cycle_sequencer_branch_resolve.sv
// Branch decision from the control flags and the ALU zero flag; shared with the pipelined core.
module branch_resolve (
  input  logic branch,
  input  logic branch_if_zero,
  input  logic branch_if_not_zero,
  input  logic alu_zero,
  output logic take
);

  assign take = branch
              | (branch_if_zero & alu_zero)
              | (branch_if_not_zero & ~alu_zero);

endmodule

// File: rtl/cycle_sequencer.sv
// Phase controller for the non-pipelined LEGv8 core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter int unsigned         CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch,
  input  logic                branch_if_zero,
  input  logic                branch_if_not_zero,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                reg_write,
  input  logic                alu_zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                ir_load,
  output logic                reg_read_en,
  output logic                alu_en,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                reg_write_en,
  output logic                pc_en,
  output logic                pc_sel,
  output logic                busy,
  output logic                halted,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instr_count
);

  seq_state_e state_q, state_d;
  logic       pc_sel_q, pc_sel_d;
  logic       take;

  branch_resolve u_branch_resolve (
    .branch             (branch),
    .branch_if_zero     (branch_if_zero),
    .branch_if_not_zero (branch_if_not_zero),
    .alu_zero           (alu_zero),
    .take               (take)
  );

  // State and latched branch decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEQ_IDLE;
      pc_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_sel_q <= pc_sel_d;
    end
  end

  // Next state and per-phase strobes
  always_comb begin
    state_d      = state_q;
    pc_sel_d     = pc_sel_q;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    reg_read_en  = 1'b0;
    alu_en       = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_en        = 1'b0;
    halted       = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (start) state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = SEQ_DECODE;
        end
      end
      SEQ_DECODE: begin
        reg_read_en = 1'b1;
        state_d     = (opcode == HALT_OPCODE) ? SEQ_HALT : SEQ_EXECUTE;
      end
      SEQ_EXECUTE: begin
        alu_en   = 1'b1;
        pc_sel_d = take;
        if (mem_read || mem_write) begin
          state_d = SEQ_MEMORY;
        end else if (reg_write) begin
          state_d = SEQ_WRITEBACK;
        end else begin
          pc_en   = 1'b1;
          state_d = SEQ_FETCH;
        end
      end
      SEQ_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write;
        if (dmem_ack) begin
          if (reg_write) begin
            state_d = SEQ_WRITEBACK;
          end else begin
            pc_en   = 1'b1;
            state_d = SEQ_FETCH;
          end
        end
      end
      SEQ_WRITEBACK: begin
        reg_write_en = 1'b1;
        pc_en        = 1'b1;
        state_d      = SEQ_FETCH;
      end
      SEQ_HALT: begin
        halted = 1'b1;
        if (start) state_d = SEQ_FETCH;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    // Each new fetch starts with a clean branch decision
    if (state_d == SEQ_FETCH) pc_sel_d = 1'b0;
  end

  // EXECUTE can retire directly, before the decision reaches pc_sel_q
  assign pc_sel = (state_q == SEQ_EXECUTE) ? take : pc_sel_q;
  assign busy   = seq_is_busy(state_q);

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             start_accept;

  assign start_accept = start && ((state_q == SEQ_IDLE) || (state_q == SEQ_HALT));

  // Busy-cycle and retired-instruction counters, wrapping at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else if (start_accept) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (busy)  cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (pc_en) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_cnt_q;
  assign instr_count = instr_cnt_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: per-cycle expected state/strobes queued and compared.
`timescale 1ns/1ps
module tb_cycle_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam logic [10:0] ALU_OP  = 11'h458;
  localparam logic [10:0] HALT_OP = 11'h7FF;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic start, imem_ack, dmem_ack, alu_zero;
    logic halt_op;
    logic branch, bz, bnz;
    logic mem_read, mem_write, reg_write;
  } stim_t;

  typedef struct packed {
    logic [2:0] st;
    logic imem_req, ir_load, reg_read_en, alu_en;
    logic dmem_req, dmem_we, reg_write_en, pc_en;
    logic pc_sel, busy, halted;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start, imem_ack, dmem_ack, alu_zero;
  logic branch, branch_if_zero, branch_if_not_zero;
  logic mem_read, mem_write, reg_write;
  logic [10:0] opcode;
  logic imem_req, ir_load, reg_read_en, alu_en, dmem_req, dmem_we;
  logic reg_write_en, pc_en, pc_sel, busy, halted;
  logic [CNT_W-1:0] cycle_count, instr_count;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cycle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .branch(branch), .branch_if_zero(branch_if_zero), .branch_if_not_zero(branch_if_not_zero),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_load(ir_load), .reg_read_en(reg_read_en), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write_en(reg_write_en), .pc_en(pc_en),
    .pc_sel(pc_sel), .busy(busy), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  function automatic exp_t observe();
    return {3'(dut.state_q), imem_req, ir_load, reg_read_en, alu_en,
            dmem_req, dmem_we, reg_write_en, pc_en, pc_sel, busy, halted};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_exp(input int n);
    return PERF ? CNT_W'(n) : '0;
  endfunction

  task automatic apply(input stim_t s);
    start              = s.start;
    imem_ack           = s.imem_ack;
    dmem_ack           = s.dmem_ack;
    alu_zero           = s.alu_zero;
    opcode             = s.halt_op ? HALT_OP : ALU_OP;
    branch             = s.branch;
    branch_if_zero     = s.bz;
    branch_if_not_zero = s.bnz;
    mem_read           = s.mem_read;
    mem_write          = s.mem_write;
    reg_write          = s.reg_write;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    apply('0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t got;
    rst_n = 1'b0;
    apply('0);
    #2;
    got = observe();
    checks++;
    if (got !== 14'b0) begin errors++; $display("FAIL reset_outputs got %b want %b", got, 14'b0); end
    checks++;
    if (cycle_count !== '0 || instr_count !== '0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", cycle_count, instr_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    got = observe();
    checks++;
    if (got !== 14'b0) begin errors++; $display("FAIL reset_idle_hold got %b want %b", got, 14'b0); end
  endtask

  task automatic test_add();
    row_t rows [6] = '{
      '{11'b1000_0_000_001, 14'b000_0000_0000_000},
      '{11'b0100_0_000_001, 14'b001_1100_0000_010},
      '{11'b0100_0_000_001, 14'b010_0010_0000_010},
      '{11'b0000_0_000_001, 14'b011_0001_0000_010},
      '{11'b0010_0_000_001, 14'b101_0000_0011_010},
      '{11'b0000_0_000_001, 14'b001_1000_0000_010}
    };
    exp_t got, want;
    reset_dut();
    foreach (rows[i]) begin
      @(negedge clk);
      apply(rows[i].s);
      exp_q.push_back(rows[i].e);
      #2;
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL add cyc %0d got %b want %b", i, got, want); end
    end
    checks++;
    if (cycle_count !== cnt_exp(4) || instr_count !== cnt_exp(1)) begin
      errors++; $display("FAIL add_counters got %0d/%0d want %0d/%0d",
                         cycle_count, instr_count, cnt_exp(4), cnt_exp(1));
    end
  endtask

  task automatic test_load_wait();
    row_t rows [10] = '{
      '{11'b1000_0_000_101, 14'b000_0000_0000_000},
      '{11'b0100_0_000_101, 14'b001_1100_0000_010},
      '{11'b0000_0_000_101, 14'b010_0010_0000_010},
      '{11'b0000_0_000_101, 14'b011_0001_0000_010},
      '{11'b0000_0_000_101, 14'b100_0000_1000_010},
      '{11'b1000_0_000_101, 14'b100_0000_1000_010},
      '{11'b0000_0_000_101, 14'b100_0000_1000_010},
      '{11'b0010_0_000_101, 14'b100_0000_1000_010},
      '{11'b0000_0_000_101, 14'b101_0000_0011_010},
      '{11'b0000_0_000_101, 14'b001_1000_0000_010}
    };
    exp_t got, want;
    reset_dut();
    foreach (rows[i]) begin
      @(negedge clk);
      apply(rows[i].s);
      exp_q.push_back(rows[i].e);
      #2;
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL load cyc %0d got %b want %b", i, got, want); end
    end
    checks++;
    if (cycle_count !== cnt_exp(8) || instr_count !== cnt_exp(1)) begin
      errors++; $display("FAIL load_counters got %0d/%0d want %0d/%0d",
                         cycle_count, instr_count, cnt_exp(8), cnt_exp(1));
    end
  endtask

  task automatic test_back_to_back();
    row_t rows [10] = '{
      '{11'b1000_0_000_010, 14'b000_0000_0000_000},
      '{11'b0100_0_000_010, 14'b001_1100_0000_010},
      '{11'b0000_0_000_010, 14'b010_0010_0000_010},
      '{11'b0000_0_000_010, 14'b011_0001_0000_010},
      '{11'b0000_0_000_010, 14'b100_0000_1100_010},
      '{11'b0010_0_000_010, 14'b100_0000_1101_010},
      '{11'b0100_0_000_000, 14'b001_1100_0000_010},
      '{11'b0000_0_000_000, 14'b010_0010_0000_010},
      '{11'b0000_0_000_000, 14'b011_0001_0001_010},
      '{11'b0000_0_000_000, 14'b001_1000_0000_010}
    };
    exp_t got, want;
    reset_dut();
    foreach (rows[i]) begin
      @(negedge clk);
      apply(rows[i].s);
      exp_q.push_back(rows[i].e);
      #2;
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL b2b cyc %0d got %b want %b", i, got, want); end
    end
    checks++;
    if (cycle_count !== cnt_exp(8) || instr_count !== cnt_exp(2)) begin
      errors++; $display("FAIL b2b_counters got %0d/%0d want %0d/%0d",
                         cycle_count, instr_count, cnt_exp(8), cnt_exp(2));
    end
  endtask

  task automatic test_branch();
    row_t rows [15] = '{
      '{11'b1000_0_010_000, 14'b000_0000_0000_000},
      '{11'b0100_0_010_000, 14'b001_1100_0000_010},
      '{11'b0000_0_010_000, 14'b010_0010_0000_010},
      '{11'b0001_0_010_000, 14'b011_0001_0001_110},
      '{11'b0100_0_010_000, 14'b001_1100_0000_010},
      '{11'b0000_0_010_000, 14'b010_0010_0000_010},
      '{11'b0000_0_010_000, 14'b011_0001_0001_010},
      '{11'b0100_0_001_000, 14'b001_1100_0000_010},
      '{11'b0000_0_001_000, 14'b010_0010_0000_010},
      '{11'b0000_0_001_000, 14'b011_0001_0001_110},
      '{11'b0100_0_100_001, 14'b001_1100_0000_010},
      '{11'b0000_0_100_001, 14'b010_0010_0000_010},
      '{11'b0001_0_100_001, 14'b011_0001_0000_110},
      '{11'b0000_0_000_001, 14'b101_0000_0011_110},
      '{11'b0000_0_000_000, 14'b001_1000_0000_010}
    };
    exp_t got, want;
    reset_dut();
    foreach (rows[i]) begin
      @(negedge clk);
      apply(rows[i].s);
      exp_q.push_back(rows[i].e);
      #2;
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL branch cyc %0d got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_halt();
    row_t rows [7] = '{
      '{11'b1000_1_000_000, 14'b000_0000_0000_000},
      '{11'b0100_1_000_000, 14'b001_1100_0000_010},
      '{11'b0000_1_000_000, 14'b010_0010_0000_010},
      '{11'b0100_1_000_000, 14'b110_0000_0000_001},
      '{11'b0000_1_000_000, 14'b110_0000_0000_001},
      '{11'b1000_1_000_000, 14'b110_0000_0000_001},
      '{11'b0000_0_000_000, 14'b001_1000_0000_010}
    };
    exp_t got, want;
    reset_dut();
    foreach (rows[i]) begin
      @(negedge clk);
      apply(rows[i].s);
      exp_q.push_back(rows[i].e);
      #2;
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL halt cyc %0d got %b want %b", i, got, want); end
      if (i == 4) begin
        checks++;
        if (cycle_count !== cnt_exp(2) || instr_count !== cnt_exp(0)) begin
          errors++; $display("FAIL halt_counters got %0d/%0d want %0d/%0d",
                             cycle_count, instr_count, cnt_exp(2), cnt_exp(0));
        end
      end
    end
    checks++;
    if (cycle_count !== '0 || instr_count !== '0) begin
      errors++; $display("FAIL restart_counters got %0d/%0d want 0/0", cycle_count, instr_count);
    end
  endtask

  task automatic test_reset_mid_mem();
    row_t rows [5] = '{
      '{11'b1000_0_000_100, 14'b000_0000_0000_000},
      '{11'b0100_0_000_100, 14'b001_1100_0000_010},
      '{11'b0000_0_000_100, 14'b010_0010_0000_010},
      '{11'b0000_0_000_100, 14'b011_0001_0000_010},
      '{11'b0000_0_000_100, 14'b100_0000_1000_010}
    };
    exp_t got, want;
    reset_dut();
    foreach (rows[i]) begin
      @(negedge clk);
      apply(rows[i].s);
      exp_q.push_back(rows[i].e);
      #2;
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL memrst cyc %0d got %b want %b", i, got, want); end
    end
    #1 rst_n = 1'b0;
    #1;
    got = observe();
    checks++;
    if (got !== 14'b0) begin errors++; $display("FAIL memrst_async got %b want %b", got, 14'b0); end
    @(negedge clk);
    @(negedge clk);
    apply(11'b0010_0_000_100);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      got = observe();
      checks++;
      if (got !== 14'b0) begin errors++; $display("FAIL memrst_late_ack %0d got %b want %b", k, got, 14'b0); end
      @(negedge clk);
    end
  endtask

  task automatic test_counter_wrap();
    exp_t phase_exp [3] = '{14'b001_1100_0000_010, 14'b010_0010_0000_010, 14'b011_0001_0001_010};
    exp_t got, want;
    int pc_pulses = 0;
    reset_dut();
    @(negedge clk);
    apply(11'b1000_0_000_000);
    #2;
    for (int k = 0; k < 51; k++) begin
      @(negedge clk);
      apply((k % 3 == 0) ? 11'b0100_0_000_000 : 11'b0000_0_000_000);
      exp_q.push_back(phase_exp[k % 3]);
      #2;
      got = observe();
      want = exp_q.pop_front();
      if (got.pc_en) pc_pulses++;
      checks++;
      if (got !== want) begin errors++; $display("FAIL wrap cyc %0d got %b want %b", k, got, want); end
    end
    @(negedge clk);
    apply('0);
    #2;
    checks++;
    if (pc_pulses != 17) begin errors++; $display("FAIL wrap_pc_en got %0d want 17", pc_pulses); end
    checks++;
    if (instr_count !== cnt_exp(17)) begin
      errors++; $display("FAIL wrap_instr_count got %0d want %0d", instr_count, cnt_exp(17));
    end
    checks++;
    if (cycle_count !== cnt_exp(51)) begin
      errors++; $display("FAIL wrap_cycle_count got %0d want %0d", cycle_count, cnt_exp(51));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply('0);
    test_reset();
    test_add();
    test_load_wait();
    test_back_to_back();
    test_branch();
    test_halt();
    test_reset_mid_mem();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
